// File: rtl/lock_ctrl_pkg.sv
// Shared types and sizing helpers for the configuration-register lock controller.
package lock_ctrl_pkg;

    typedef enum logic [2:0] {
        UNLOCKED,
        LOCKED,
        KEY1_WAIT,
        DEBUG,
        LOCKOUT
    } lock_state_t;

    localparam int FAIL_W = 3;

    // Enough bits to hold max(timeout, session) - 1, never less than one bit.
    function automatic int timer_w(input int timeout, input int session);
        int m;
        m = (timeout > session) ? timeout : session;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int TIMER_W = timer_w(16, 256);

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a zero flag; serves both the KEY1 window and the debug session.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/register_lock_ctrl.sv
// Lock-policy FSM driving lock_status/debug_unlocked of the locked configuration register.
module register_lock_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter logic [15:0] KEY0     = 16'hA5C3,
    parameter logic [15:0] KEY1     = 16'h3C5A,
    parameter int          TIMEOUT  = 16,
    parameter int          SESSION  = 256,
    parameter int          MAX_FAIL = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lock_req,
    input  logic              key_valid,
    input  logic [15:0]       key_data,
    input  logic              debug_exit,
    output logic              lock_status,
    output logic              debug_unlocked,
    output logic              lockout,
    output logic [FAIL_W-1:0] fail_count
);

    localparam int                TW       = timer_w(TIMEOUT, SESSION);
    localparam logic [TW-1:0]     TMO_LD   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     SES_LD   = TW'(SESSION - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

    function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] c);
        return (c >= FAIL_MAX) ? FAIL_MAX : c + FAIL_W'(1);
    endfunction

    lock_state_t       r_state;
    lock_state_t       w_state_nxt;
    lock_state_t       w_fail_dst;
    logic [FAIL_W-1:0] r_fail_cnt;
    logic [FAIL_W-1:0] w_fail_nxt;
    logic [FAIL_W-1:0] w_fail_inc;
    logic              r_lock_status;
    logic              r_debug_unlocked;
    logic              r_lockout;
    logic              w_tmr_load;
    logic [TW-1:0]     w_tmr_val;
    logic              w_tmr_dec;
    logic              w_tmr_zero;

    lock_timer #(
        .W(TW)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .i_dec     (w_tmr_dec),
        .o_zero    (w_tmr_zero)
    );

    // A failure that reaches the limit escalates straight to the terminal state.
    assign w_fail_inc = sat_inc(r_fail_cnt);
    assign w_fail_dst = (w_fail_inc == FAIL_MAX) ? LOCKOUT : LOCKED;

    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail_cnt;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_dec   = 1'b0;
        case (r_state)
            UNLOCKED: begin
                if (lock_req) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (key_valid) begin
                    if (key_data == KEY0) begin
                        w_state_nxt = KEY1_WAIT;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMO_LD;
                    end else begin
                        w_fail_nxt  = w_fail_inc;
                        w_state_nxt = w_fail_dst;
                    end
                end
            end
            KEY1_WAIT: begin
                // A key in the final window cycle beats expiry.
                if (key_valid) begin
                    if (key_data == KEY1) begin
                        w_state_nxt = DEBUG;
                        w_fail_nxt  = '0;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = SES_LD;
                    end else begin
                        w_fail_nxt  = w_fail_inc;
                        w_state_nxt = w_fail_dst;
                    end
                end else if (w_tmr_zero) begin
                    w_fail_nxt  = w_fail_inc;
                    w_state_nxt = w_fail_dst;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            DEBUG: begin
                if (debug_exit || w_tmr_zero) begin
                    w_state_nxt = LOCKED;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            LOCKOUT: begin
                w_state_nxt = LOCKOUT;
            end
            default: begin
                w_state_nxt = UNLOCKED;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state          <= UNLOCKED;
            r_fail_cnt       <= '0;
            r_lock_status    <= 1'b0;
            r_debug_unlocked <= 1'b0;
            r_lockout        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_fail_cnt       <= w_fail_nxt;
            r_lock_status    <= (w_state_nxt == LOCKED) || (w_state_nxt == KEY1_WAIT) ||
                                (w_state_nxt == LOCKOUT);
            r_debug_unlocked <= (w_state_nxt == DEBUG);
            r_lockout        <= (w_state_nxt == LOCKOUT);
        end
    end

    assign lock_status    = r_lock_status;
    assign debug_unlocked = r_debug_unlocked;
    assign lockout        = r_lockout;
    assign fail_count     = r_fail_cnt;

endmodule
